// File: rtl/gate_truth_table_checker.sv
// Self-checking sweep stage for a two-input gate block: drives a/b through all
// four vectors, compares the six gate outputs to a golden model and reports the result.
module gate_truth_table_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       and_in,
    input  logic       or_in,
    input  logic       nand_in,
    input  logic       nor_in,
    input  logic       xor_in,
    input  logic       xnor_in,
    output logic       a,
    output logic       b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_mask,
    output logic [2:0] fail_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    // Expected gate outputs, bit order matches err_mask
    function automatic logic [5:0] golden(input logic op_a, input logic op_b);
        return {~(op_a ^ op_b), op_a ^ op_b, ~(op_a | op_b), ~(op_a & op_b), op_a | op_b, op_a & op_b};
    endfunction

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] vec_idx_q, vec_idx_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       pass_q, pass_d;
    logic [5:0] err_mask_q, err_mask_d;
    logic [2:0] fail_cnt_q, fail_cnt_d;
    logic [5:0] sampled_s;
    logic [5:0] mismatch_s;
    logic [1:0] next_idx_s;

    // Next-state and datapath update for the sweep FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        vec_idx_d  = vec_idx_q;
        a_d        = a_q;
        b_d        = b_q;
        pass_d     = pass_q;
        err_mask_d = err_mask_q;
        fail_cnt_d = fail_cnt_q;
        sampled_s  = {xnor_in, xor_in, nor_in, nand_in, or_in, and_in};
        mismatch_s = sampled_s ^ golden(a_q, b_q);
        next_idx_s = vec_idx_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_idx_d  = 2'd0;
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                    err_mask_d = 6'd0;
                    fail_cnt_d = 3'd0;
                    pass_d     = 1'b0;
                    cnt_d      = SETTLE_LD;
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_mask_d = err_mask_q | mismatch_s;
                    if (mismatch_s != 6'd0) begin
                        fail_cnt_d = fail_cnt_q + 3'd1;
                    end else begin
                        fail_cnt_d = fail_cnt_q;
                    end
                    if (vec_idx_q != 2'd3) begin
                        vec_idx_d = next_idx_s;
                        a_d       = next_idx_s[1];
                        b_d       = next_idx_s[0];
                        cnt_d     = SETTLE_LD;
                    end else begin
                        state_d = ST_DONE;
                        pass_d  = ((err_mask_q | mismatch_s) == 6'd0);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            vec_idx_q  <= 2'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            pass_q     <= 1'b0;
            err_mask_q <= 6'd0;
            fail_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vec_idx_q  <= vec_idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            pass_q     <= pass_d;
            err_mask_q <= err_mask_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign vec_idx  = vec_idx_q;
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign pass     = pass_q;
    assign err_mask = err_mask_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: three checker instances (SETTLE_CYCLES 2, 1, 15) around
// behavioural gate models, one of which can inject known faults.
module tb_gate_truth_table_checker;

    logic clk = 1'b0;
    logic rst;
    logic start;
    int   mode;

    logic a0, b0, busy0, done0, pass0;
    logic [1:0] vi0;
    logic [5:0] em0;
    logic [2:0] fc0;
    logic g_and, g_or, g_nand, g_nor, g_xor, g_xnor;

    logic a1, b1, busy1, done1, pass1;
    logic [1:0] vi1;
    logic [5:0] em1;
    logic [2:0] fc1;

    logic a15, b15, busy15, done15, pass15;
    logic [1:0] vi15;
    logic [5:0] em15;
    logic [2:0] fc15;

    int vectors_applied = 0;
    int miscompares     = 0;

    always #5 clk = ~clk;

    // Gate model for the main instance: 0 correct, 1 NAND stuck 0 when a=0, 2 XOR/XNOR swapped
    always_comb begin
        g_and  = a0 & b0;
        g_or   = a0 | b0;
        g_nand = ~(a0 & b0);
        g_nor  = ~(a0 | b0);
        g_xor  = a0 ^ b0;
        g_xnor = ~(a0 ^ b0);
        if (mode == 1 && !a0) g_nand = 1'b0;
        if (mode == 2) begin
            g_xor  = ~(a0 ^ b0);
            g_xnor = a0 ^ b0;
        end
    end

    gate_truth_table_checker #(.SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .and_in(g_and), .or_in(g_or), .nand_in(g_nand), .nor_in(g_nor),
        .xor_in(g_xor), .xnor_in(g_xnor),
        .a(a0), .b(b0), .vec_idx(vi0), .busy(busy0), .done(done0),
        .pass(pass0), .err_mask(em0), .fail_cnt(fc0)
    );

    gate_truth_table_checker #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .start(start),
        .and_in(a1 & b1), .or_in(a1 | b1), .nand_in(~(a1 & b1)), .nor_in(~(a1 | b1)),
        .xor_in(a1 ^ b1), .xnor_in(~(a1 ^ b1)),
        .a(a1), .b(b1), .vec_idx(vi1), .busy(busy1), .done(done1),
        .pass(pass1), .err_mask(em1), .fail_cnt(fc1)
    );

    gate_truth_table_checker #(.SETTLE_CYCLES(15)) u_dut_s15 (
        .clk(clk), .rst(rst), .start(start),
        .and_in(a15 & b15), .or_in(a15 | b15), .nand_in(~(a15 & b15)), .nor_in(~(a15 | b15)),
        .xor_in(a15 ^ b15), .xnor_in(~(a15 ^ b15)),
        .a(a15), .b(b15), .vec_idx(vi15), .busy(busy15), .done(done15),
        .pass(pass15), .err_mask(em15), .fail_cnt(fc15)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start pulse; edge n=1 is the edge that samples start. Records the edge
    // on which each instance first shows done and how many done cycles instance 0 showed.
    task automatic sweep(input bit check_seq, output int t2, output int t1, output int t15,
                         output int dones0);
        logic [1:0] ev;
        t2 = 0; t1 = 0; t15 = 0; dones0 = 0;
        start = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            tick();
            start = 1'b0;
            if (done0) dones0++;
            if (done0 && t2 == 0) t2 = n;
            if (done1 && t1 == 0) t1 = n;
            if (done15 && t15 == 0) t15 = n;
            if (check_seq && n <= 12) begin
                ev = 2'((n - 1) / 3);
                check_eq($sformatf("seq_idx_e%0d", n), {30'd0, vi0}, {30'd0, ev});
                check_eq($sformatf("seq_ab_e%0d", n), {30'd0, a0, b0}, {30'd0, ev});
            end
        end
    endtask

    initial begin
        int t2, t1, t15, nd;
        int budget;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        tick();
        tick();
        check_eq("reset_outs", {18'd0, a0, b0, vi0, busy0, done0, pass0, em0, fc0}, 32'd0);
        rst = 1'b0;
        tick();

        // Test 1 + 6: correct gates, timing for all three settle lengths
        sweep(1'b1, t2, t1, t15, nd);
        check_eq("t1_done_edge_s2", t2, 32'd13);
        check_eq("t1_done_pulses", nd, 32'd1);
        check_eq("t1_result", {23'd0, pass0, em0, fc0}, {23'd0, 1'b1, 6'h00, 3'd0});
        check_eq("t6_done_edge_s1", t1, 32'd9);
        check_eq("t6_done_edge_s15", t15, 32'd65);
        check_eq("t6_pass_s1", {31'd0, pass1}, 32'd1);
        check_eq("t6_pass_s15", {31'd0, pass15}, 32'd1);
        repeat (3) tick();
        check_eq("t1_pass_held", {23'd0, pass0, em0, fc0}, {23'd0, 1'b1, 6'h00, 3'd0});

        // Test 2: NAND stuck low while a=0
        mode = 1;
        sweep(1'b0, t2, t1, t15, nd);
        check_eq("t2_done_edge", t2, 32'd13);
        check_eq("t2_result", {23'd0, pass0, em0, fc0}, {23'd0, 1'b0, 6'b000100, 3'd2});

        // Test 3: XOR/XNOR swapped
        mode = 2;
        sweep(1'b0, t2, t1, t15, nd);
        check_eq("t3_result", {23'd0, pass0, em0, fc0}, {23'd0, 1'b0, 6'b110000, 3'd4});

        // Test 4: reset during vector 2
        mode  = 0;
        start = 1'b1;
        tick();
        start  = 1'b0;
        budget = 0;
        while (vi0 != 2'd2 && budget < 20) begin
            tick();
            budget++;
        end
        check_eq("t4_reach_vec2", {31'd0, vi0 == 2'd2}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t4_reset_outs", {18'd0, a0, b0, vi0, busy0, done0, pass0, em0, fc0}, 32'd0);
        nd = 0;
        repeat (20) begin
            tick();
            if (done0) nd++;
        end
        check_eq("t4_no_done", nd, 32'd0);
        sweep(1'b0, t2, t1, t15, nd);
        check_eq("t4_clean_sweep", {23'd0, pass0, em0, fc0}, {23'd0, 1'b1, 6'h00, 3'd0});

        // Test 5: start held high, faulty NAND so stale counts would show
        mode  = 1;
        start = 1'b1;
        nd    = 0;
        for (int n = 1; n <= 42; n++) begin
            tick();
            if (done0) begin
                nd++;
                check_eq($sformatf("t5_sweep%0d_result", nd), {23'd0, pass0, em0, fc0},
                         {23'd0, 1'b0, 6'b000100, 3'd2});
                check_eq($sformatf("t5_sweep%0d_edge", nd), n, 32'(14 * nd - 1));
            end
        end
        start = 1'b0;
        check_eq("t5_done_count", nd, 32'd3);
        repeat (70) tick();
        check_eq("t5_idle_after", {31'd0, busy0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
